key_press_ctrl: RTL and testbench
=================================

KEY_PRESS_CTRL -- requirements
Module: key_press_ctrl

Interface
REQ-001 Parameter LONG_CNT, default 50_000_000, SHALL be the hold length in clk cycles that qualifies a long press (1 s at 50 MHz); legal range 2..2^26-1.
REQ-002 Parameter DCLK_CNT, default 15_000_000, SHALL be the double-click window in clk cycles after a release (300 ms at 50 MHz); legal range 2..2^26-1.
REQ-003 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: one clock; reset is synchronous and active-high.
REQ-005 pos_edge  input  1  SHALL be a one-cycle pulse from the edge checker marking key release (debounced key rises).
REQ-006 neg_edge  input  1  SHALL be a one-cycle pulse from the edge checker marking key press (debounced key falls).
REQ-007 short_press  output  1  SHALL be a one-cycle registered pulse marking a single short press.
REQ-008 long_press  output  1  SHALL be a one-cycle registered pulse marking a long press.
REQ-009 double_press  output  1  SHALL be a one-cycle registered pulse marking a double press.
REQ-010 led  output  2  SHALL be the registered LED mode driven to the board LEDs.
REQ-011 busy  output  1  SHALL be high whenever the state machine is not in IDLE.

Function
REQ-012 Press classifier SHALL be a 5-state FSM: IDLE, PRESSED, WAIT_2ND, PRESSED_2, LONG_HELD, with one shared 26-bit cycle counter cnt.
REQ-013 In any state, pos_edge and neg_edge both high in the same cycle SHALL be treated as no event.
REQ-014 IDLE: neg_edge -> PRESSED, cnt=0; pos_edge ignored.
REQ-015 PRESSED: cnt increments each cycle; pos_edge -> WAIT_2ND, cnt=0; else cnt==LONG_CNT-1 -> LONG_HELD with long_press pulsed; pos_edge takes priority over the count match in the same cycle.
REQ-016 WAIT_2ND: cnt increments; neg_edge -> PRESSED_2, cnt=0; else cnt==DCLK_CNT-1 -> IDLE with short_press pulsed; neg_edge takes priority over the count match.
REQ-017 PRESSED_2: cnt increments; pos_edge -> IDLE with double_press pulsed; else cnt==LONG_CNT-1 -> LONG_HELD with long_press pulsed (pending double discarded).
REQ-018 LONG_HELD: pos_edge -> IDLE; neg_edge ignored; cnt held.
REQ-019 Latency: neg_edge in cycle t with no pos_edge in t+1..t+LONG_CNT SHALL give long_press in cycle t+LONG_CNT+1.
REQ-020 Latency: pos_edge in cycle r entering WAIT_2ND with no neg_edge in r+1..r+DCLK_CNT SHALL give short_press in cycle r+DCLK_CNT+1.
REQ-021 Latency: pos_edge in cycle s while in PRESSED_2 SHALL give double_press in cycle s+1.
REQ-022 At most one of short_press, long_press, double_press SHALL be high in any cycle; each SHALL be high for exactly one cycle per event.
REQ-023 led SHALL update on the same clock edge that asserts an event pulse: short_press toggles led[0]; long_press toggles led[1]; double_press sets led to 2'b11 if it was 2'b00, else 2'b00.
REQ-024 cnt SHALL never exceed max(LONG_CNT, DCLK_CNT)-1; no wrap-around occurs.

Reset
REQ-025 rst high at a clock edge SHALL force state IDLE, cnt=0, short_press=0, long_press=0, double_press=0, led=2'b00, busy=0, overriding any edge input in that cycle.
REQ-026 rst asserted mid-classification (any non-IDLE state) SHALL abandon the press with no event pulse emitted, either during reset or after its release.
REQ-027 First cycle after rst deasserts SHALL accept a neg_edge normally.

Verification (LONG_CNT=20, DCLK_CNT=8)
REQ-028 neg_edge cycle 10, pos_edge cycle 15 -> short_press high only in cycle 24; led 00->01; busy low from cycle 24.
REQ-029 neg_edge cycle 10, no release -> long_press high only in cycle 31; led 00->10; pos_edge cycle 40 -> IDLE, no further pulse.
REQ-030 neg 10, pos 14, neg 18, pos 21 -> double_press high only in cycle 22; no short_press; led 00->11; repeat sequence -> led 11->00.
REQ-031 pos_edge and neg_edge together in IDLE, then in PRESSED -> no state change, no pulses; separately, pos_edge in cycle 30 after neg_edge in cycle 10 (coincides with count match) -> WAIT_2ND, no long_press.
REQ-032 neg_edge cycle 10, rst high cycles 20-21 -> no pulses, led=00, busy=0 from cycle 21; neg_edge cycle 22 -> busy=1 in cycle 23.

Source files
------------

// File: rtl/key_press_ctrl.sv
// Key press classifier: turns debounced press/release pulses into short, long
// and double press events, and keeps a 2-bit LED mode that those events drive.
module key_press_ctrl #(
  parameter int LONG_CNT = 50_000_000,
  parameter int DCLK_CNT = 15_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pos_edge,
  input  logic       neg_edge,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic [1:0] led,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    WAIT_2ND  = 3'd2,
    PRESSED_2 = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  localparam logic [25:0] LONG_LAST = 26'(LONG_CNT - 1);
  localparam logic [25:0] DCLK_LAST = 26'(DCLK_CNT - 1);

  state_t      state, state_n;
  logic [25:0] cnt, cnt_n;
  logic        short_n, long_n, double_n;
  logic [1:0]  led_n;
  logic        press_ev, rel_ev;

  // Simultaneous press and release pulses cancel out and count as no event.
  assign press_ev = neg_edge & ~pos_edge;
  assign rel_ev   = pos_edge & ~neg_edge;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (press_ev) state_n = PRESSED;
      end
      PRESSED: begin
        if (rel_ev) begin
          state_n = WAIT_2ND;
          cnt_n   = '0;
        end else if (cnt == LONG_LAST) begin
          state_n = LONG_HELD;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + 26'd1;
        end
      end
      WAIT_2ND: begin
        if (press_ev) begin
          state_n = PRESSED_2;
          cnt_n   = '0;
        end else if (cnt == DCLK_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          short_n = 1'b1;
        end else begin
          cnt_n = cnt + 26'd1;
        end
      end
      PRESSED_2: begin
        // A second press held long enough becomes a long press; the double is dropped.
        if (rel_ev) begin
          state_n  = IDLE;
          cnt_n    = '0;
          double_n = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = LONG_HELD;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + 26'd1;
        end
      end
      LONG_HELD: begin
        if (rel_ev) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    led_n = led;
    if (short_n)  led_n = led ^ 2'b01;
    if (long_n)   led_n = led ^ 2'b10;
    if (double_n) led_n = (led == 2'b00) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      led          <= 2'b00;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      short_press  <= short_n;
      long_press   <= long_n;
      double_press <= double_n;
      led          <= led_n;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_key_press_ctrl.sv
// Directed bench for key_press_ctrl with LONG_CNT=20, DCLK_CNT=8; cycle c of a
// scenario is the c-th clock period after reset is released.
module tb_key_press_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pos_edge;
  logic       neg_edge;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic [1:0] led;
  logic       busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int passed = 0;

  key_press_ctrl #(.LONG_CNT(20), .DCLK_CNT(8)) dut (
    .clk(clk), .rst(rst), .pos_edge(pos_edge), .neg_edge(neg_edge),
    .short_press(short_press), .long_press(long_press), .double_press(double_press),
    .led(led), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; pos_edge = 1'b0; neg_edge = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp_p;
    reset_dut();
    for (int c = 0; c <= 24; c++) begin
      neg_edge = (c == 0);
      rst      = (c == 23);
      pos_edge = (c == 23);
      exp_p    = (c == 21) ? 3'b010 : 3'b000;
      checks++;
      if ({short_press, long_press, double_press} !== exp_p)
        $display("FAIL reset_pulses c=%0d got %b exp %b", c, {short_press, long_press, double_press}, exp_p);
      else passed++;
      if (c == 22) begin
        checks++;
        if (led !== 2'b10) $display("FAIL reset_led_pre c=%0d got %b exp 10", c, led);
        else passed++;
      end
      if (c == 24) begin
        checks++;
        if ({led, busy, state_dbg} !== 6'b000000)
          $display("FAIL reset_state c=%0d got led=%b busy=%b st=%0d exp led=00 busy=0 st=0", c, led, busy, state_dbg);
        else passed++;
      end
      tick();
    end
    neg_edge = 1'b0; pos_edge = 1'b0; rst = 1'b0;
  endtask

  task automatic test_short();
    logic [2:0] exp_p;
    logic [1:0] exp_led;
    logic       exp_busy;
    reset_dut();
    for (int c = 0; c <= 30; c++) begin
      neg_edge = (c == 10);
      pos_edge = (c == 15);
      exp_p    = (c == 24) ? 3'b100 : 3'b000;
      exp_led  = (c >= 24) ? 2'b01 : 2'b00;
      exp_busy = (c >= 11 && c <= 23);
      checks++;
      if ({short_press, long_press, double_press} !== exp_p)
        $display("FAIL short_pulses c=%0d got %b exp %b", c, {short_press, long_press, double_press}, exp_p);
      else passed++;
      if (c == 23 || c == 24 || c == 30) begin
        checks++;
        if ({led, busy} !== {exp_led, exp_busy})
          $display("FAIL short_led_busy c=%0d got led=%b busy=%b exp led=%b busy=%b", c, led, busy, exp_led, exp_busy);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_long();
    logic [2:0] exp_p;
    logic [1:0] exp_led;
    logic       exp_busy;
    reset_dut();
    for (int c = 0; c <= 52; c++) begin
      neg_edge = (c == 10 || c == 35);
      pos_edge = (c == 40);
      exp_p    = (c == 31) ? 3'b010 : 3'b000;
      exp_led  = (c >= 31) ? 2'b10 : 2'b00;
      exp_busy = (c >= 11 && c <= 40);
      checks++;
      if ({short_press, long_press, double_press} !== exp_p)
        $display("FAIL long_pulses c=%0d got %b exp %b", c, {short_press, long_press, double_press}, exp_p);
      else passed++;
      if (c == 30 || c == 31 || c == 40 || c == 41) begin
        checks++;
        if ({led, busy} !== {exp_led, exp_busy})
          $display("FAIL long_led_busy c=%0d got led=%b busy=%b exp led=%b busy=%b", c, led, busy, exp_led, exp_busy);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_double();
    logic [2:0] exp_p;
    logic [1:0] exp_led;
    reset_dut();
    for (int c = 0; c <= 45; c++) begin
      neg_edge = (c == 10 || c == 18 || c == 25 || c == 29);
      pos_edge = (c == 14 || c == 21 || c == 27 || c == 31);
      exp_p    = (c == 22 || c == 32) ? 3'b001 : 3'b000;
      exp_led  = (c >= 22 && c < 32) ? 2'b11 : 2'b00;
      checks++;
      if ({short_press, long_press, double_press} !== exp_p)
        $display("FAIL double_pulses c=%0d got %b exp %b", c, {short_press, long_press, double_press}, exp_p);
      else passed++;
      if (c == 21 || c == 22 || c == 31 || c == 32) begin
        checks++;
        if (led !== exp_led) $display("FAIL double_led c=%0d got %b exp %b", c, led, exp_led);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_both_edges();
    logic [2:0] exp_p;
    reset_dut();
    for (int c = 0; c <= 32; c++) begin
      neg_edge = (c == 5 || c == 10 || c == 15);
      pos_edge = (c == 5 || c == 15 || c == 17);
      exp_p    = (c == 26) ? 3'b100 : 3'b000;
      checks++;
      if ({short_press, long_press, double_press} !== exp_p)
        $display("FAIL both_pulses c=%0d got %b exp %b", c, {short_press, long_press, double_press}, exp_p);
      else passed++;
      if (c == 6 || c == 16) begin
        checks++;
        if ({busy, state_dbg} !== ((c == 6) ? 4'b0000 : 4'b1001))
          $display("FAIL both_state c=%0d got busy=%b st=%0d exp busy=%0d st=%0d", c, busy, state_dbg, c == 16, (c == 16) ? 1 : 0);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_release_at_match();
    logic [2:0] exp_p;
    reset_dut();
    for (int c = 0; c <= 45; c++) begin
      neg_edge = (c == 10);
      pos_edge = (c == 30);
      exp_p    = (c == 39) ? 3'b100 : 3'b000;
      checks++;
      if ({short_press, long_press, double_press} !== exp_p)
        $display("FAIL match_pulses c=%0d got %b exp %b", c, {short_press, long_press, double_press}, exp_p);
      else passed++;
      if (c == 31) begin
        checks++;
        if (state_dbg !== 3'd2) $display("FAIL match_state c=%0d got %0d exp 2", c, state_dbg);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_window_edges();
    logic [2:0] exp_p;
    reset_dut();
    // Second press lands on the last window cycle; then a held second press goes long.
    for (int c = 0; c <= 70; c++) begin
      neg_edge = (c == 10 || c == 22 || c == 30 || c == 34);
      pos_edge = (c == 14 || c == 24 || c == 32 || c == 60);
      exp_p    = (c == 25) ? 3'b001 : (c == 55) ? 3'b010 : 3'b000;
      checks++;
      if ({short_press, long_press, double_press} !== exp_p)
        $display("FAIL window_pulses c=%0d got %b exp %b", c, {short_press, long_press, double_press}, exp_p);
      else passed++;
      if (c == 56) begin
        checks++;
        if (led !== 2'b01) $display("FAIL window_led c=%0d got %b exp 01", c, led);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] exp_p;
    reset_dut();
    for (int c = 0; c <= 50; c++) begin
      neg_edge = (c == 10 || c == 22);
      pos_edge = (c == 25);
      rst      = (c == 20 || c == 21);
      exp_p    = (c == 34) ? 3'b100 : 3'b000;
      checks++;
      if ({short_press, long_press, double_press} !== exp_p)
        $display("FAIL midrst_pulses c=%0d got %b exp %b", c, {short_press, long_press, double_press}, exp_p);
      else passed++;
      if (c == 21 || c == 22 || c == 23) begin
        checks++;
        if ({led, busy} !== {2'b00, c == 23})
          $display("FAIL midrst_busy c=%0d got led=%b busy=%b exp led=00 busy=%0d", c, led, busy, c == 23);
        else passed++;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pos_edge = 1'b0; neg_edge = 1'b0;
    test_short();
    test_reset();
    test_long();
    test_double();
    test_both_edges();
    test_release_at_match();
    test_window_edges();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
